// File: rtl/execute_stage_if.sv
// Bundles the ID/EX operands, forwarding sources and EX/MEM results of the execute stage.
interface execute_stage_if;
    logic [3:0]  ex_i;
    logic [2:0]  m_i;
    logic [1:0]  wb_i;
    logic [4:0]  rs_i, rt_i, rd_i;
    logic [31:0] imm_i, data_1_i, data_2_i;
    logic [4:0]  mem_rd_i, wb_rd_i;
    logic        mem_reg_write_i, wb_reg_write_i;
    logic [31:0] mem_fwd_data_i, wb_fwd_data_i;
    logic        stall_ex_o;
    logic [1:0]  wb_o;
    logic [2:0]  m_o;
    logic [31:0] alu_result_o, store_data_o;
    logic [4:0]  dest_reg_o;
    logic        md_busy_o, ovf_exc_o;

    modport slave (
        input  ex_i, m_i, wb_i, rs_i, rt_i, rd_i, imm_i, data_1_i, data_2_i,
               mem_rd_i, wb_rd_i, mem_reg_write_i, wb_reg_write_i,
               mem_fwd_data_i, wb_fwd_data_i,
        output stall_ex_o, wb_o, m_o, alu_result_o, store_data_o, dest_reg_o,
               md_busy_o, ovf_exc_o
    );

    modport master (
        output ex_i, m_i, wb_i, rs_i, rt_i, rd_i, imm_i, data_1_i, data_2_i,
               mem_rd_i, wb_rd_i, mem_reg_write_i, wb_reg_write_i,
               mem_fwd_data_i, wb_fwd_data_i,
        input  stall_ex_o, wb_o, m_o, alu_result_o, store_data_o, dest_reg_o,
               md_busy_o, ovf_exc_o
    );
endinterface

// File: rtl/execute_stage.sv
// MIPS R2000 EX stage: operand forwarding, ALU, iterative mul/div with HI/LO, EX/MEM register.
// Optional macro OVF_TRAP_EN: signed add/sub overflow squashes the instruction and pulses ovf_exc_o.
module execute_stage #(
    parameter int MD_CYCLES = 32
) (
    input  logic           clk,
    input  logic           rst,
    execute_stage_if.slave bus
);
    localparam int CNT_W = $clog2(MD_CYCLES + 1);

    typedef enum logic [1:0] {MD_IDLE, MD_MULT, MD_DIV} md_state_t;

    function automatic logic [31:0] neg32(input logic n, input logic [31:0] v);
        return n ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] neg64(input logic n, input logic [63:0] v);
        return n ? (~v + 64'd1) : v;
    endfunction

    md_state_t          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        hi_q, lo_q, acc_q, wrk_q, mcand_q;
    logic               neg_q, neg_rem_q, dz_q;

    logic [1:0]         wb_q, wb_d;
    logic [2:0]         m_q, m_d;
    logic [31:0]        alu_q, alu_d, store_q, store_d;
    logic [4:0]         dest_q, dest_d;

    logic [5:0]         funct;
    logic [4:0]         shamt;
    logic [1:0]         alu_op;
    logic signed [31:0] op_a, fwd_b, op_b, sum, diff;
    logic               is_r, is_hilo, is_md, md_signed, md_busy, stall, wr_en;
    logic [31:0]        res;
    logic [32:0]        madd, rem_sh, trial;
    logic [31:0]        step_acc, step_wrk;
    logic               unused_imm;

    assign funct      = bus.imm_i[5:0];
    assign shamt      = bus.imm_i[10:6];
    assign alu_op     = bus.ex_i[2:1];
    assign unused_imm = ^bus.imm_i[31:16];
    assign is_r       = (alu_op == 2'b10);
    assign is_hilo    = is_r && (funct inside {6'h10, 6'h11, 6'h12, 6'h13});
    assign is_md      = is_r && (funct inside {6'h18, 6'h19, 6'h1A, 6'h1B});
    assign md_signed  = ~funct[0];
    assign md_busy    = (state_q != MD_IDLE);
    assign stall      = md_busy && (is_hilo || is_md);

    // MEM stage result is younger than WB, so it is applied last and wins.
    always_comb begin
        op_a = bus.data_1_i;
        if (bus.wb_reg_write_i && bus.wb_rd_i != 5'd0 && bus.wb_rd_i == bus.rs_i)
            op_a = bus.wb_fwd_data_i;
        if (bus.mem_reg_write_i && bus.mem_rd_i != 5'd0 && bus.mem_rd_i == bus.rs_i)
            op_a = bus.mem_fwd_data_i;
        fwd_b = bus.data_2_i;
        if (bus.wb_reg_write_i && bus.wb_rd_i != 5'd0 && bus.wb_rd_i == bus.rt_i)
            fwd_b = bus.wb_fwd_data_i;
        if (bus.mem_reg_write_i && bus.mem_rd_i != 5'd0 && bus.mem_rd_i == bus.rt_i)
            fwd_b = bus.mem_fwd_data_i;
    end

    assign op_b = bus.ex_i[0] ? {{16{bus.imm_i[15]}}, bus.imm_i[15:0]} : fwd_b;
    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;

    always_comb begin
        res   = '0;
        wr_en = 1'b1;
        case (alu_op)
            2'b01: res = diff;
            2'b10: begin
                case (funct)
                    6'h20, 6'h21: res = sum;
                    6'h22, 6'h23: res = diff;
                    6'h24:        res = op_a & op_b;
                    6'h25:        res = op_a | op_b;
                    6'h26:        res = op_a ^ op_b;
                    6'h27:        res = ~(op_a | op_b);
                    6'h2A:        res = {31'd0, op_a < op_b};
                    6'h2B:        res = {31'd0, $unsigned(op_a) < $unsigned(op_b)};
                    6'h00:        res = fwd_b << shamt;
                    6'h02:        res = fwd_b >> shamt;
                    6'h03:        res = fwd_b >>> shamt;
                    6'h10:        res = hi_q;
                    6'h12:        res = lo_q;
                    6'h11, 6'h13: res = '0;
                    default:      wr_en = 1'b0;
                endcase
            end
            default: res = sum;
        endcase
    end

`ifdef OVF_TRAP_EN
    logic trap, ovf_d, ovf_q;
    assign trap = is_r &&
                  ((funct == 6'h20 && op_a[31] == op_b[31] && sum[31] != op_a[31]) ||
                   (funct == 6'h22 && op_a[31] != op_b[31] && diff[31] != op_a[31]));
`endif

    always_comb begin
        wb_d    = '0;
        m_d     = '0;
        alu_d   = '0;
        store_d = '0;
        dest_d  = '0;
`ifdef OVF_TRAP_EN
        ovf_d   = 1'b0;
`endif
        if (!stall) begin
            wb_d    = wr_en ? bus.wb_i : 2'b00;
            m_d     = bus.m_i;
            alu_d   = res;
            store_d = fwd_b;
            dest_d  = bus.ex_i[3] ? bus.rd_i : bus.rt_i;
`ifdef OVF_TRAP_EN
            if (trap) begin
                wb_d  = 2'b00;
                m_d   = 3'b000;
                ovf_d = 1'b1;
            end
`endif
        end
    end

    // EX/MEM pipeline register boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q    <= '0;
            m_q     <= '0;
            alu_q   <= '0;
            store_q <= '0;
            dest_q  <= '0;
`ifdef OVF_TRAP_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            wb_q    <= wb_d;
            m_q     <= m_d;
            alu_q   <= alu_d;
            store_q <= store_d;
            dest_q  <= dest_d;
`ifdef OVF_TRAP_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // One engine bit per cycle: shift-add multiply on magnitudes, or restoring divide.
    always_comb begin
        madd   = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, mcand_q} : 33'd0);
        rem_sh = {acc_q, wrk_q[31]};
        trial  = rem_sh - {1'b0, mcand_q};
        if (state_q == MD_DIV) begin
            if (!trial[32]) begin
                step_acc = trial[31:0];
                step_wrk = {wrk_q[30:0], 1'b1};
            end else begin
                step_acc = rem_sh[31:0];
                step_wrk = {wrk_q[30:0], 1'b0};
            end
        end else begin
            step_acc = madd[32:1];
            step_wrk = {madd[0], wrk_q[31:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            wrk_q     <= '0;
            mcand_q   <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (is_r && funct == 6'h11) hi_q <= op_a;
                    if (is_r && funct == 6'h13) lo_q <= op_a;
                    if (is_md) begin
                        state_q   <= funct[1] ? MD_DIV : MD_MULT;
                        cnt_q     <= '0;
                        acc_q     <= '0;
                        wrk_q     <= neg32(md_signed && op_a[31], op_a);
                        mcand_q   <= neg32(md_signed && op_b[31], op_b);
                        neg_q     <= md_signed && (op_a[31] ^ op_b[31]);
                        neg_rem_q <= md_signed && op_a[31];
                        dz_q      <= (op_b == 32'sd0);
                    end
                end
                default: begin
                    acc_q <= step_acc;
                    wrk_q <= step_wrk;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(MD_CYCLES - 1)) begin
                        state_q <= MD_IDLE;
                        if (state_q == MD_DIV) begin
                            hi_q <= neg32(neg_rem_q, step_acc);
                            lo_q <= dz_q ? 32'hFFFF_FFFF : neg32(neg_q, step_wrk);
                        end else begin
                            {hi_q, lo_q} <= neg64(neg_q, {step_acc, step_wrk});
                        end
                    end
                end
            endcase
        end
    end

    assign bus.stall_ex_o   = stall;
    assign bus.wb_o         = wb_q;
    assign bus.m_o          = m_q;
    assign bus.alu_result_o = alu_q;
    assign bus.store_data_o = store_q;
    assign bus.dest_reg_o   = dest_q;
    assign bus.md_busy_o    = md_busy;
`ifdef OVF_TRAP_EN
    assign bus.ovf_exc_o    = ovf_q;
`else
    assign bus.ovf_exc_o    = 1'b0;
`endif
endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage: ALU, forwarding, mul/div stalls, reset.
module tb_execute_stage;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    execute_stage_if bus ();

    execute_stage #(.MD_CYCLES(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [5:0]  tf [12] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h3F};
    logic [31:0] ta [12] = '{32'h5, 32'h5, 32'hF0F0_00FF, 32'hF0F0_00FF, 32'hF0F0_00FF,
                             32'h0000_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0,
                             32'h0, 32'h5};
    logic [31:0] tb_ [12] = '{32'h7, 32'h7, 32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'h0FF0_0F0F,
                              32'h00FF_0000, 32'h1, 32'h1, 32'h3, 32'h8000_0000,
                              32'h8000_0000, 32'h7};
    logic [4:0]  ts [12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0,
                             5'd4, 5'd4, 5'd4, 5'd0};
    logic [31:0] te [12] = '{32'd12, 32'hFFFF_FFFE, 32'h00F0_000F, 32'hFFF0_0FFF,
                             32'hFF00_0FF0, 32'hFF00_0000, 32'h1, 32'h0, 32'h30,
                             32'h0800_0000, 32'hF800_0000, 32'h0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        bus.mem_rd_i = 5'd0;        bus.wb_rd_i = 5'd0;
        bus.mem_reg_write_i = 1'b0; bus.wb_reg_write_i = 1'b0;
        bus.mem_fwd_data_i = 32'h0; bus.wb_fwd_data_i = 32'h0;
    endtask

    task automatic set_nop();
        bus.ex_i = 4'b0000; bus.m_i = 3'b000; bus.wb_i = 2'b00;
        bus.rs_i = 5'd0; bus.rt_i = 5'd0; bus.rd_i = 5'd0;
        bus.imm_i = 32'h0; bus.data_1_i = 32'h0; bus.data_2_i = 32'h0;
    endtask

    task automatic set_r(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] shamt);
        bus.ex_i = 4'b1100; bus.m_i = 3'b000; bus.wb_i = 2'b10;
        bus.rs_i = 5'd1; bus.rt_i = 5'd2; bus.rd_i = 5'd9;
        bus.imm_i = {16'h0, 5'd9, shamt, funct};
        bus.data_1_i = a; bus.data_2_i = b;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.md_busy_o && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_fwd();
        set_r(6'h20, 32'h5, 32'h7, 5'd0);
        step();
        step();
        checks++; if (bus.wb_o !== 2'b00) begin errors++; $display("FAIL reset_wb: got %b expected 00", bus.wb_o); end
        checks++; if (bus.m_o !== 3'b000) begin errors++; $display("FAIL reset_m: got %b expected 000", bus.m_o); end
        checks++; if (bus.alu_result_o !== 32'h0) begin errors++; $display("FAIL reset_alu: got %h expected 0", bus.alu_result_o); end
        checks++; if (bus.store_data_o !== 32'h0) begin errors++; $display("FAIL reset_store: got %h expected 0", bus.store_data_o); end
        checks++; if (bus.dest_reg_o !== 5'd0) begin errors++; $display("FAIL reset_dest: got %0d expected 0", bus.dest_reg_o); end
        checks++; if (bus.md_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.md_busy_o); end
        checks++; if (bus.ovf_exc_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf_exc_o); end
        checks++; if (bus.stall_ex_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall_ex_o); end
        rst = 1'b0;
    endtask

    task automatic test_rtype_add();
        set_r(6'h20, 32'h5, 32'h7, 5'd0);
        step();
        checks++; if (bus.alu_result_o !== 32'd12) begin errors++; $display("FAIL add_result: got %h expected 0000000c", bus.alu_result_o); end
        checks++; if (bus.dest_reg_o !== 5'd9) begin errors++; $display("FAIL add_dest: got %0d expected 9", bus.dest_reg_o); end
        checks++; if (bus.wb_o !== 2'b10) begin errors++; $display("FAIL add_wb: got %b expected 10", bus.wb_o); end
    endtask

    task automatic test_alu_funct();
        for (int i = 0; i < 12; i++) begin
            set_r(tf[i], ta[i], tb_[i], ts[i]);
            step();
            checks++;
            if (bus.alu_result_o !== te[i]) begin
                errors++;
                $display("FAIL alu_funct_%h: got %h expected %h", tf[i], bus.alu_result_o, te[i]);
            end
            checks++;
            if (bus.wb_o !== ((tf[i] == 6'h3F) ? 2'b00 : 2'b10)) begin
                errors++;
                $display("FAIL alu_wb_%h: got %b", tf[i], bus.wb_o);
            end
        end
    endtask

    task automatic test_forward();
        set_r(6'h21, 32'h1, 32'h0, 5'd0);
        bus.rs_i = 5'd3; bus.rt_i = 5'd4;
        bus.mem_rd_i = 5'd3; bus.mem_reg_write_i = 1'b1; bus.mem_fwd_data_i = 32'hAAAA_0000;
        bus.wb_rd_i  = 5'd3; bus.wb_reg_write_i  = 1'b1; bus.wb_fwd_data_i  = 32'h1111_1111;
        step();
        checks++; if (bus.alu_result_o !== 32'hAAAA_0000) begin errors++; $display("FAIL fwd_mem_priority: got %h expected aaaa0000", bus.alu_result_o); end
        bus.mem_reg_write_i = 1'b0;
        step();
        checks++; if (bus.alu_result_o !== 32'h1111_1111) begin errors++; $display("FAIL fwd_wb: got %h expected 11111111", bus.alu_result_o); end
        bus.rs_i = 5'd0; bus.mem_rd_i = 5'd0; bus.wb_rd_i = 5'd0;
        bus.mem_reg_write_i = 1'b1; bus.wb_reg_write_i = 1'b1;
        step();
        checks++; if (bus.alu_result_o !== 32'h1) begin errors++; $display("FAIL fwd_r0: got %h expected 00000001", bus.alu_result_o); end
        bus.rs_i = 5'd3; bus.wb_reg_write_i = 1'b0;
        bus.mem_rd_i = 5'd4; bus.mem_fwd_data_i = 32'h10; bus.data_2_i = 32'h99;
        step();
        checks++; if (bus.store_data_o !== 32'h10) begin errors++; $display("FAIL fwd_b_store: got %h expected 00000010", bus.store_data_o); end
        checks++; if (bus.alu_result_o !== 32'h11) begin errors++; $display("FAIL fwd_b_alu: got %h expected 00000011", bus.alu_result_o); end
        clear_fwd();
    endtask

    task automatic test_itype();
        bus.ex_i = 4'b0001; bus.m_i = 3'b010; bus.wb_i = 2'b11;
        bus.rs_i = 5'd2; bus.rt_i = 5'd8; bus.rd_i = 5'd31;
        bus.imm_i = 32'h0000_FFFC; bus.data_1_i = 32'h100; bus.data_2_i = 32'hDEAD_BEEF;
        step();
        checks++; if (bus.alu_result_o !== 32'h0000_00FC) begin errors++; $display("FAIL lw_addr: got %h expected 000000fc", bus.alu_result_o); end
        checks++; if (bus.dest_reg_o !== 5'd8) begin errors++; $display("FAIL lw_dest: got %0d expected 8", bus.dest_reg_o); end
        checks++; if (bus.m_o !== 3'b010) begin errors++; $display("FAIL lw_m: got %b expected 010", bus.m_o); end
        checks++; if (bus.store_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_store: got %h expected deadbeef", bus.store_data_o); end
        bus.ex_i = 4'b0010; bus.m_i = 3'b100; bus.wb_i = 2'b00;
        bus.imm_i = 32'h0; bus.data_1_i = 32'd9; bus.data_2_i = 32'd4;
        step();
        checks++; if (bus.alu_result_o !== 32'd5) begin errors++; $display("FAIL beq_sub: got %h expected 00000005", bus.alu_result_o); end
        checks++; if (bus.m_o !== 3'b100) begin errors++; $display("FAIL beq_m: got %b expected 100", bus.m_o); end
    endtask

    task automatic test_mult();
        int n;
        set_r(6'h18, 32'hFFFF_FFFE, 32'h3, 5'd0);
        step();
        checks++; if (bus.wb_o !== 2'b00) begin errors++; $display("FAIL mult_wb: got %b expected 00", bus.wb_o); end
        checks++; if (bus.md_busy_o !== 1'b1) begin errors++; $display("FAIL mult_busy: got %b expected 1", bus.md_busy_o); end
        set_r(6'h12, 32'h0, 32'h0, 5'd0);
        #1;
        n = 0;
        while (bus.stall_ex_o && n < 100) begin
            step();
            n++;
            if (n == 1) begin
                checks++;
                if (bus.wb_o !== 2'b00 || bus.alu_result_o !== 32'h0 || bus.dest_reg_o !== 5'd0) begin
                    errors++;
                    $display("FAIL stall_bubble: got wb=%b alu=%h dest=%0d expected zeros", bus.wb_o, bus.alu_result_o, bus.dest_reg_o);
                end
            end
        end
        checks++; if (n !== 32) begin errors++; $display("FAIL mult_stall_len: got %0d expected 32", n); end
        step();
        checks++; if (bus.alu_result_o !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo: got %h expected fffffffa", bus.alu_result_o); end
        checks++; if (bus.wb_o !== 2'b10) begin errors++; $display("FAIL mflo_wb: got %b expected 10", bus.wb_o); end
        set_r(6'h10, 32'h0, 32'h0, 5'd0);
        step();
        checks++; if (bus.alu_result_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", bus.alu_result_o); end
    endtask

    task automatic run_div(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int n;
        set_r(funct, a, b, 5'd0);
        step();
        set_nop();
        wait_idle(n);
        checks++; if (n !== 32) begin errors++; $display("FAIL div_%h_busy_len: got %0d expected 32", funct, n); end
        set_r(6'h12, 32'h0, 32'h0, 5'd0);
        step();
        checks++; if (bus.alu_result_o !== exp_lo) begin errors++; $display("FAIL div_%h_lo: got %h expected %h", funct, bus.alu_result_o, exp_lo); end
        set_r(6'h10, 32'h0, 32'h0, 5'd0);
        step();
        checks++; if (bus.alu_result_o !== exp_hi) begin errors++; $display("FAIL div_%h_hi: got %h expected %h", funct, bus.alu_result_o, exp_hi); end
    endtask

    task automatic test_div();
        run_div(6'h1B, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7);
        run_div(6'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    endtask

    task automatic test_mthi_mtlo();
        set_r(6'h11, 32'h1234_5678, 32'h0, 5'd0);
        step();
        checks++; if (bus.alu_result_o !== 32'h0) begin errors++; $display("FAIL mthi_result: got %h expected 0", bus.alu_result_o); end
        set_r(6'h13, 32'h9ABC_DEF0, 32'h0, 5'd0);
        step();
        set_r(6'h10, 32'h0, 32'h0, 5'd0);
        step();
        checks++; if (bus.alu_result_o !== 32'h1234_5678) begin errors++; $display("FAIL mthi_read: got %h expected 12345678", bus.alu_result_o); end
        set_r(6'h12, 32'h0, 32'h0, 5'd0);
        step();
        checks++; if (bus.alu_result_o !== 32'h9ABC_DEF0) begin errors++; $display("FAIL mtlo_read: got %h expected 9abcdef0", bus.alu_result_o); end
    endtask

    task automatic test_overflow();
        set_r(6'h20, 32'h7FFF_FFFF, 32'h1, 5'd0);
        step();
`ifdef OVF_TRAP_EN
        checks++; if (bus.ovf_exc_o !== 1'b1) begin errors++; $display("FAIL ovf_exc: got %b expected 1", bus.ovf_exc_o); end
        checks++; if (bus.wb_o !== 2'b00) begin errors++; $display("FAIL ovf_wb: got %b expected 00", bus.wb_o); end
        set_nop();
        step();
        checks++; if (bus.ovf_exc_o !== 1'b0) begin errors++; $display("FAIL ovf_pulse: got %b expected 0", bus.ovf_exc_o); end
`else
        checks++; if (bus.alu_result_o !== 32'h8000_0000) begin errors++; $display("FAIL ovf_add_result: got %h expected 80000000", bus.alu_result_o); end
        checks++; if (bus.wb_o !== 2'b10) begin errors++; $display("FAIL ovf_add_wb: got %b expected 10", bus.wb_o); end
        checks++; if (bus.ovf_exc_o !== 1'b0) begin errors++; $display("FAIL ovf_tied: got %b expected 0", bus.ovf_exc_o); end
`endif
        set_r(6'h21, 32'h7FFF_FFFF, 32'h1, 5'd0);
        step();
        checks++; if (bus.alu_result_o !== 32'h8000_0000) begin errors++; $display("FAIL addu_wrap: got %h expected 80000000", bus.alu_result_o); end
        checks++; if (bus.wb_o !== 2'b10 || bus.ovf_exc_o !== 1'b0) begin errors++; $display("FAIL addu_no_trap: got wb=%b ovf=%b expected 10/0", bus.wb_o, bus.ovf_exc_o); end
    endtask

    task automatic test_reset_mid_mult();
        set_r(6'h19, 32'd3, 32'd3, 5'd0);
        step();
        set_nop();
        repeat (5) step();
        checks++; if (bus.md_busy_o !== 1'b1) begin errors++; $display("FAIL midmult_busy: got %b expected 1", bus.md_busy_o); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus.md_busy_o !== 1'b0) begin errors++; $display("FAIL midmult_abort: got %b expected 0", bus.md_busy_o); end
        repeat (40) step();
        set_r(6'h12, 32'h0, 32'h0, 5'd0);
        step();
        checks++; if (bus.alu_result_o !== 32'h0) begin errors++; $display("FAIL midmult_lo: got %h expected 0", bus.alu_result_o); end
        set_r(6'h10, 32'h0, 32'h0, 5'd0);
        step();
        checks++; if (bus.alu_result_o !== 32'h0) begin errors++; $display("FAIL midmult_hi: got %h expected 0", bus.alu_result_o); end
    endtask

    initial begin
        test_reset();
        test_rtype_add();
        test_alu_funct();
        test_forward();
        test_itype();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_overflow();
        test_reset_mid_mult();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Pipeline EX stage of the MIPS R2000 core, directly downstream of the decode stage.
- Consumes the ID/EX register outputs: ex, m, wb, rs, rt, rd, imm, data_1, data_2.
- Performs operand forwarding, ALU operations and iterative multiply/divide with HI/LO registers.
- Drives the EX/MEM pipeline register and a stall request back to fetch/decode.

Parameters:
MD_CYCLES, 32, iteration count of the multiply/divide engine (shift-add / restoring divide, one bit per cycle)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
ex_i  in  4  {reg_dst, alu_op[1:0], alu_src}
m_i  in  3  {branch, mem_read, mem_write}
wb_i  in  2  {reg_write, mem_to_reg}
rs_i, rt_i, rd_i  in  5  register numbers from ID/EX
imm_i  in  32  zero-extended imm; [5:0]=funct, [10:6]=shamt
data_1_i, data_2_i  in  32  register-file operands
mem_rd_i, wb_rd_i  in  5  destination regs in MEM and WB stages
mem_reg_write_i, wb_reg_write_i  in  1  write enables in MEM/WB
mem_fwd_data_i, wb_fwd_data_i  in  32  forwardable results
stall_ex_o  out  1  combinational; upstream must hold PC, IF/ID and ID/EX while high
wb_o  out  2  EX/MEM wb field
m_o  out  3  EX/MEM m field
alu_result_o  out  32  EX/MEM ALU/HI/LO result
store_data_o  out  32  forwarded rt operand for stores
dest_reg_o  out  5  reg_dst ? rd_i : rt_i
md_busy_o  out  1  multiply/divide engine active
ovf_exc_o  out  1  registered overflow exception (OVF_TRAP_EN only, else 0)

Behaviour:
- Reset: all EX/MEM outputs 0; HI=LO=0; engine to IDLE; md_busy_o=0; ovf_exc_o=0. Reset mid-operation aborts the engine without updating HI/LO.
- Forwarding, per operand (A from rs, B from rt):
  - MEM match wins over WB match.
  - Match requires write enable=1 and rd!=0.
  - Otherwise use data_1_i / data_2_i.
- B-operand mux: alu_src ? sign-extended imm_i[15:0] : forwarded rt.
- ALU:
  - alu_op=00 and 11: add.
  - alu_op=01: subtract.
  - alu_op=10: decode by funct:
    - 20/21 add/addu, 22/23 sub/subu, 24 and, 25 or, 26 xor, 27 nor
    - 2A slt (signed), 2B sltu
    - 00 sll, 02 srl, 03 sra (shift rt by shamt)
    - 10 mfhi, 12 mflo
    - 11 mthi, 13 mtlo (write A into HI/LO at edge; result 0)
    - 18 mult, 19 multu, 1A div, 1B divu (launch engine; result 0; wb_o forced 00)
    - Unknown funct: result 0, wb_o forced 00.
  - All arithmetic is modulo 2^32.
- Latency: one cycle; EX/MEM captures at each rising edge unless stalled.
- Engine FSM: IDLE -> MULT or DIV on launch -> IDLE after MD_CYCLES iterations.
  - Launch at cycle T: busy for T+1..T+MD_CYCLES.
  - HI/LO written at the edge ending cycle T+MD_CYCLES; readable at T+MD_CYCLES+1.
  - Signed ops work on magnitudes and sign-fix at the end.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - mult: HI:LO = 64-bit product. div: LO = quotient, HI = remainder.
  - Divide by zero: LO=FFFFFFFF, HI=dividend; no exception.
- stall_ex_o=1 when md_busy_o=1 and the EX instruction is mfhi, mflo, mthi, mtlo, or an md launch.
  - Stall cycle: EX/MEM captures a bubble (wb=00, m=000, others 0); the instruction is re-evaluated next cycle.
  - The stall clears combinationally in the cycle HI/LO become readable.
- Simultaneous mthi/mtlo while idle and engine completion cannot occur, because completion implies busy.

Optional Feature:
- Macro: OVF_TRAP_EN.
- Defined:
  - Signed overflow on funct 20/22 forces wb_o=00 and m_o=000 for that instruction.
  - ovf_exc_o=1 for exactly one cycle, aligned with the EX/MEM capture.
- Undefined:
  - add/sub behave like addu/subu.
  - ovf_exc_o tied to 0.

Test Plan:
- R-type add, data_1=5, data_2=7, ex=1100, wb=10, rd=9 -> next cycle alu_result_o=12, dest_reg_o=9, wb_o=10.
- Forward priority: rs=3; MEM rd=3 data AAAA_0000; WB rd=3 data 1111_1111 -> operand A=AAAA_0000. With rd=0 in both stages -> data_1_i used.
- lw, imm=FFFC (ex=0001, data_1=100) -> alu_result_o=0000_00FC, dest_reg_o=rt, m_o=010.
- mult with A=FFFF_FFFE (-2), B=3, then mflo next cycle -> stall_ex_o=1 for 32 cycles, bubbles emitted; then alu_result_o=FFFF_FFFA; mfhi gives FFFF_FFFF.
- divu 7/0 -> LO=FFFF_FFFF, HI=7. div -7/2 -> LO=FFFF_FFFD, HI=FFFF_FFFF.
- OVF_TRAP_EN: add 7FFF_FFFF+1 -> ovf_exc_o=1 one cycle, wb_o=00. Without the macro -> result 8000_0000, wb_o=10. Reset asserted mid-mult -> md_busy_o=0, HI=LO=0.
